// File: rtl/ro_puf_controller_pkg.sv
// Shared package for the ring-oscillator PUF controller: the FSM state type,
// default parameter values and the two-hot enable helper.
package puf_pkg;

  // Default build parameters for the controller.
  localparam int PUF_N_RO   = 16;
  localparam int PUF_CNT_W  = 16;
  localparam int PUF_SETTLE = 8;
  localparam int PUF_WINDOW = 1024;

  // The enable helper works on a fixed-size vector. Arrays of up to 256 rings are supported.
  localparam int PUF_IDX_W  = 8;
  localparam int PUF_MAX_RO = 1 << PUF_IDX_W;

  // Sequencer states. The ST_ prefix keeps these names apart from the SETTLE/WINDOW parameters.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } puf_state_e;

  // Build the enable vector with exactly the two selected rings switched on.
  function automatic logic [PUF_MAX_RO-1:0] two_hot(input logic [PUF_IDX_W-1:0] idx_a,
                                                    input logic [PUF_IDX_W-1:0] idx_b);
    logic [PUF_MAX_RO-1:0] vec;
    vec        = '0;
    vec[idx_a] = 1'b1;
    vec[idx_b] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/ro_puf_controller_edge_counter.sv
// One measurement channel: a two-flop synchronizer on the selected ring output,
// a rising-edge detector and a saturating edge counter with clear and enable.
module ro_edge_counter
  import puf_pkg::*;
#(
  parameter int CNT_W = PUF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ro_sample,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rise;

  // Synchronizer and edge detector run all the time. The counter moves only while enabled and stops at full scale.
  always_comb begin
    sync1_d = ro_sample;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && rise && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ro_puf_controller.sv
// Ring-oscillator PUF sequencer. For each request it decodes a challenge into two ring indices.
// It enables those two rings, lets them settle, counts their edges over a fixed window,
// and reports which ring was faster as a single response bit.
module ro_puf_controller
  import puf_pkg::*;
#(
  parameter int N_RO   = PUF_N_RO,
  parameter int SEL_W  = $clog2(N_RO),
  parameter int CNT_W  = PUF_CNT_W,
  parameter int SETTLE = PUF_SETTLE,
  parameter int WINDOW = PUF_WINDOW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*SEL_W-1:0] challenge,
  input  logic [N_RO-1:0]    ro_in,
  output logic [N_RO-1:0]    ro_en,
  output logic               busy,
  output logic               done,
  output logic               response,
  output logic               tie,
  output logic               err,
  output logic [CNT_W-1:0]   count_a,
  output logic [CNT_W-1:0]   count_b
);

  // A single timer covers both the settle phase and the counting window.
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);

  puf_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SEL_W-1:0] idx_a_q, idx_a_d;
  logic [SEL_W-1:0] idx_b_q, idx_b_d;
  logic             mux_a_q, mux_a_d;
  logic             mux_b_q, mux_b_d;
  logic [N_RO-1:0]  ro_en_q, ro_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             response_q, response_d;
  logic             tie_q, tie_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_a_q, count_a_d;
  logic [CNT_W-1:0] count_b_q, count_b_d;

  logic [SEL_W-1:0] ch_a;
  logic [SEL_W-1:0] ch_b;
  logic             meas_clear;
  logic             meas_en;
  logic [CNT_W-1:0] live_a;
  logic [CNT_W-1:0] live_b;

  assign ch_a = challenge[2*SEL_W-1:SEL_W];
  assign ch_b = challenge[SEL_W-1:0];

  // Next-state logic for the sequencer, the phase timer and the challenge register.
  // Counters are cleared on the last settle cycle so they start at zero on the first counting cycle.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_a_d    = idx_a_q;
    idx_b_d    = idx_b_q;
    meas_clear = 1'b0;
    meas_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_a_d = ch_a;
          idx_b_d = ch_b;
          timer_d = '0;
          state_d = (ch_a == ch_b) ? ST_DONE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          timer_d    = '0;
          meas_clear = 1'b1;
          state_d    = ST_MEASURE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        meas_en = 1'b1;
        if (timer_q == WINDOW_LAST) begin
          timer_d = '0;
          state_d = ST_COMPARE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_COMPARE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The enable, busy and done outputs are decoded from the next state and then registered.
  // This keeps them glitch-free toward the oscillator array and still meets the cycle timing.
  always_comb begin
    ro_en_d = '0;
    if ((state_d == ST_SETTLE) || (state_d == ST_MEASURE)) begin
      ro_en_d = N_RO'(two_hot(PUF_IDX_W'(idx_a_d), PUF_IDX_W'(idx_b_d)));
    end
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE) || (state_d == ST_COMPARE);
    done_d = (state_d == ST_DONE);
  end

  // Registered muxes pick the two selected ring outputs ahead of the channel synchronizers.
  always_comb begin
    mux_a_d = ro_in[idx_a_q];
    mux_b_d = ro_in[idx_b_q];
  end

  // Result fields are held between requests. They change when a comparison finishes or when an equal-index request is rejected.
  always_comb begin
    response_d = response_q;
    tie_d      = tie_q;
    err_d      = err_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    if (state_q == ST_COMPARE) begin
      response_d = (live_a > live_b);
      tie_d      = (live_a == live_b);
      err_d      = 1'b0;
      count_a_d  = live_a;
      count_b_d  = live_b;
    end else if ((state_q == ST_IDLE) && start && (ch_a == ch_b)) begin
      response_d = 1'b0;
      tie_d      = 1'b0;
      err_d      = 1'b1;
      count_a_d  = '0;
      count_b_d  = '0;
    end
  end

  // Controller registers with synchronous reset back to an idle, fully cleared state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      idx_a_q    <= '0;
      idx_b_q    <= '0;
      mux_a_q    <= 1'b0;
      mux_b_q    <= 1'b0;
      ro_en_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
      err_q      <= 1'b0;
      count_a_q  <= '0;
      count_b_q  <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_a_q    <= idx_a_d;
      idx_b_q    <= idx_b_d;
      mux_a_q    <= mux_a_d;
      mux_b_q    <= mux_b_d;
      ro_en_q    <= ro_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      response_q <= response_d;
      tie_q      <= tie_d;
      err_q      <= err_d;
      count_a_q  <= count_a_d;
      count_b_q  <= count_b_d;
    end
  end

  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_chan_a (
    .clk       (clk),
    .reset     (reset),
    .ro_sample (mux_a_q),
    .clear     (meas_clear),
    .enable    (meas_en),
    .count     (live_a)
  );

  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_chan_b (
    .clk       (clk),
    .reset     (reset),
    .ro_sample (mux_b_q),
    .clear     (meas_clear),
    .enable    (meas_en),
    .count     (live_b)
  );

  assign ro_en    = ro_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = response_q;
  assign tie      = tie_q;
  assign err      = err_q;
  assign count_a  = count_a_q;
  assign count_b  = count_b_q;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Bench for ro_puf_controller. Bench-side square waves stand in for the ring oscillators.
// A scoreboard queue holds the expected result of each request until its done pulse.
module tb_ro_puf_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  challenge;
  logic        ro1, ro2, ro3, ro5, roFast;
  logic [15:0] ro_in;
  logic [15:0] ro_en;
  logic        busy, done, response, tie, err;
  logic [15:0] count_a, count_b;

  logic        satStart;
  logic [7:0]  satChallenge;
  logic [15:0] satRoIn;
  logic [15:0] satRoEn;
  logic        satBusy, satDone, satResponse, satTie, satErr;
  logic [5:0]  satCountA, satCountB;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic response;
    logic tie;
    logic err;
    int   aLo;
    int   aHi;
    int   bLo;
    int   bHi;
    int   doneCycle;
  } exp_t;

  exp_t expQ[$];

  assign ro_in   = {10'b0, ro5, 1'b0, ro3, ro2, ro1, 1'b0};
  assign satRoIn = {15'b0, roFast};

  ro_puf_controller #(
    .N_RO(16), .CNT_W(16), .SETTLE(8), .WINDOW(1024)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge), .ro_in(ro_in),
    .ro_en(ro_en), .busy(busy), .done(done), .response(response), .tie(tie),
    .err(err), .count_a(count_a), .count_b(count_b)
  );

  ro_puf_controller #(
    .N_RO(16), .CNT_W(6), .SETTLE(8), .WINDOW(1024)
  ) dutSat (
    .clk(clk), .reset(reset), .start(satStart), .challenge(satChallenge), .ro_in(satRoIn),
    .ro_en(satRoEn), .busy(satBusy), .done(satDone), .response(satResponse), .tie(satTie),
    .err(satErr), .count_a(satCountA), .count_b(satCountB)
  );

  // 10 ns system clock.
  initial forever #5 clk = ~clk;

  // Ring stand-ins. Their edges are offset from the clock edges. ro3 toggles every 4 clocks and ro5 every 5 clocks.
  initial begin
    ro3 = 1'b0;
    #3;
    forever #40 ro3 = ~ro3;
  end

  initial begin
    ro5 = 1'b0;
    #3;
    forever #50 ro5 = ~ro5;
  end

  // ro1 and ro2 are identical waves that toggle every 8 clocks, so the two channels should tie.
  initial begin
    ro1 = 1'b0;
    ro2 = 1'b0;
    #3;
    forever #80 begin
      ro1 = ~ro1;
      ro2 = ~ro2;
    end
  end

  // Fast ring for the saturation instance: it toggles every 2 clocks.
  initial begin
    roFast = 1'b0;
    #3;
    forever #20 roFast = ~roFast;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: time limit reached, observed no end of test, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
    assertCount++;
    assert (((observed >= lo) && (observed <= hi)) === 1'b1) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
    end
  endtask

  // Drive one start pulse at a negedge. On return the time is just past the sampling edge (edge 0).
  task automatic applyStimulus(input logic [7:0] ch, input exp_t e, input bit expectDone);
    @(negedge clk);
    start     = 1'b1;
    challenge = ch;
    if (expectDone) expQ.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait, within a cycle budget, for the done pulse that follows the last start.
  // Check the enables along the way, then check the popped expectation at done and one cycle later.
  task automatic waitDone(input int budget, input logic [15:0] expEn);
    int   n;
    bit   seen;
    bit   anyEn;
    bit   anyBusy;
    exp_t e;
    n = 1;
    seen = 1'b0;
    anyEn = 1'b0;
    anyBusy = 1'b0;
    while ((n <= budget) && !seen) begin
      @(negedge clk);
      if (busy === 1'b1) anyBusy = 1'b1;
      if (ro_en !== 16'h0) anyEn = 1'b1;
      if (n == 1) begin
        checkOutput("busy_first_cycle", 32'(busy), 32'(expEn != 16'h0));
        checkOutput("ro_en_first_cycle", 32'(ro_en), 32'(expEn));
      end
      if (n == 600) checkOutput("ro_en_measure", 32'(ro_en), 32'(expEn));
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    if (!seen) return;
    checkOutput("scoreboard_entry", 32'(expQ.size()), 32'd1);
    if (expQ.size() == 0) return;
    e = expQ.pop_front();
    checkOutput("done_cycle", n, e.doneCycle);
    checkOutput("response", 32'(response), 32'(e.response));
    checkOutput("tie", 32'(tie), 32'(e.tie));
    checkOutput("err", 32'(err), 32'(e.err));
    checkRange("count_a", int'(count_a), e.aLo, e.aHi);
    checkRange("count_b", int'(count_b), e.bLo, e.bHi);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("ro_en_at_done", 32'(ro_en), 32'd0);
    checkOutput("busy_seen", 32'(anyBusy), 32'(expEn != 16'h0));
    checkOutput("ro_en_seen", 32'(anyEn), 32'(expEn != 16'h0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("response_held", 32'(response), 32'(e.response));
    checkRange("count_a_held", int'(count_a), e.aLo, e.aHi);
  endtask

  // Directed sequence: reset state, compare runs, equal-index rejection, saturation, reset mid-window.
  initial begin
    int   n;
    int   doneCount;
    int   doneAt;
    bit   sawDone;
    exp_t e;

    reset        = 1'b1;
    start        = 1'b0;
    challenge    = 8'h00;
    satStart     = 1'b0;
    satChallenge = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ro_en", 32'(ro_en), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_response", 32'(response), 32'd0);
    checkOutput("reset_tie", 32'(tie), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_count_a", 32'(count_a), 32'd0);
    checkOutput("reset_count_b", 32'(count_b), 32'd0);
    reset = 1'b0;

    $display("[TB] challenge {3,5}");
    e = '{response:1'b1, tie:1'b0, err:1'b0, aLo:127, aHi:129, bLo:101, bHi:103, doneCycle:1034};
    applyStimulus(8'h35, e, 1'b1);
    waitDone(1200, 16'h0028);

    $display("[TB] challenge {5,3}");
    e = '{response:1'b0, tie:1'b0, err:1'b0, aLo:101, aHi:103, bLo:127, bHi:129, doneCycle:1034};
    applyStimulus(8'h53, e, 1'b1);
    waitDone(1200, 16'h0028);

    $display("[TB] challenge {1,2} identical rings");
    e = '{response:1'b0, tie:1'b1, err:1'b0, aLo:64, aHi:64, bLo:64, bHi:64, doneCycle:1034};
    applyStimulus(8'h12, e, 1'b1);
    waitDone(1200, 16'h0006);

    $display("[TB] challenge {7,7} equal indices");
    e = '{response:1'b0, tie:1'b0, err:1'b1, aLo:0, aHi:0, bLo:0, bHi:0, doneCycle:1};
    applyStimulus(8'h77, e, 1'b1);
    waitDone(20, 16'h0000);

    $display("[TB] saturation with 6-bit counters, start pulsed mid-window");
    e = '{response:1'b1, tie:1'b0, err:1'b0, aLo:63, aHi:63, bLo:0, bHi:0, doneCycle:1034};
    @(negedge clk);
    satStart     = 1'b1;
    satChallenge = 8'h04;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    satStart  = 1'b0;
    n         = 1;
    doneCount = 0;
    doneAt    = 0;
    while (n <= 1100) begin
      @(negedge clk);
      if (n == 300) begin
        satStart     = 1'b1;
        satChallenge = 8'h12;
      end else begin
        satStart = 1'b0;
      end
      if (satDone === 1'b1) begin
        doneCount++;
        if (doneAt == 0) doneAt = n;
      end
      @(posedge clk);
      n++;
    end
    checkOutput("sat_done_count", doneCount, 32'd1);
    checkOutput("sat_scoreboard_entry", 32'(expQ.size()), 32'd1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("sat_done_cycle", doneAt, e.doneCycle);
      checkRange("sat_count_a", int'(satCountA), e.aLo, e.aHi);
      checkRange("sat_count_b", int'(satCountB), e.bLo, e.bHi);
      checkOutput("sat_response", 32'(satResponse), 32'(e.response));
      checkOutput("sat_tie", 32'(satTie), 32'(e.tie));
      checkOutput("sat_err", 32'(satErr), 32'(e.err));
    end
    checkOutput("sat_ro_en_after", 32'(satRoEn), 32'd0);
    checkOutput("sat_busy_after", 32'(satBusy), 32'd0);

    $display("[TB] reset during window");
    applyStimulus(8'h35, e, 1'b0);
    repeat (507) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    checkOutput("pre_reset_err_held", 32'(err), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ro_en", 32'(ro_en), 32'd0);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkOutput("post_reset_done", 32'(done), 32'd0);
    checkOutput("post_reset_response", 32'(response), 32'd0);
    checkOutput("post_reset_tie", 32'(tie), 32'd0);
    checkOutput("post_reset_err", 32'(err), 32'd0);
    checkOutput("post_reset_count_a", 32'(count_a), 32'd0);
    checkOutput("post_reset_count_b", 32'(count_b), 32'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("no_done_after_reset", 32'(sawDone), 32'd0);

    $display("[TB] fresh request after reset");
    e = '{response:1'b1, tie:1'b0, err:1'b0, aLo:127, aHi:129, bLo:101, bHi:103, doneCycle:1034};
    applyStimulus(8'h35, e, 1'b1);
    waitDone(1200, 16'h0028);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
